// File: rtl/mult_cpa_pipe.sv
// Two-stage carry-propagate adder closing the multiplier's CSA tree: low half in S1, high half in S2.
// Optional zero_flag output is enabled by defining MULT_CPA_ZERO_FLAG_EN.
module mult_cpa_pipe #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] sum_vec,
    input  logic [2*WIDTH-1:0] carry_vec,
    input  logic               op_hi,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result
`ifdef MULT_CPA_ZERO_FLAG_EN
    ,
    output logic               zero_flag
`endif
);

    // Handshake: a transfer happens on any edge where valid & ready are both high;
    // valid must hold with stable data until accepted, ready may change freely.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_lo_sum;
    logic             s1_c_lo;
    logic [WIDTH-1:0] s1_up_sum;
    logic [WIDTH-1:0] s1_up_carry;
    logic             s1_op_hi;

    logic             s2_free;
    logic             s1_adv;
    logic             in_xfer;
    logic [WIDTH:0]   lo_add;
    logic [WIDTH-1:0] hi_sum;
    logic [WIDTH-1:0] sel_word;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free && !flush;
    assign in_ready = !flush && (!s1_valid || s2_free);
    assign in_xfer  = in_valid && in_ready;

    // carry_vec bit i weighs 2^(i+1), so the low half sees carry bits W-2..0 shifted up one.
    assign lo_add   = {1'b0, sum_vec[WIDTH-1:0]} + {1'b0, carry_vec[WIDTH-2:0], 1'b0};
    assign hi_sum   = s1_up_sum + s1_up_carry + {{(WIDTH-1){1'b0}}, s1_c_lo};
    assign sel_word = s1_op_hi ? hi_sum : s1_lo_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_lo_sum   <= '0;
            s1_c_lo     <= 1'b0;
            s1_up_sum   <= '0;
            s1_up_carry <= '0;
            s1_op_hi    <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_xfer) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (in_xfer) begin
                s1_lo_sum   <= lo_add[WIDTH-1:0];
                s1_c_lo     <= lo_add[WIDTH];
                s1_up_sum   <= sum_vec[2*WIDTH-1:WIDTH];
                s1_up_carry <= carry_vec[2*WIDTH-2:WIDTH-1];
                s1_op_hi    <= op_hi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s1_adv) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s1_adv) begin
                result <= sel_word;
            end
        end
    end

`ifdef MULT_CPA_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
        end else if (flush) begin
            zero_flag <= 1'b0;
        end else if (s1_adv) begin
            zero_flag <= (sel_word == '0);
        end
    end
`endif

endmodule

// File: tb/tb_mult_cpa_pipe.sv
// Randomised and directed bench for mult_cpa_pipe against a plain-arithmetic product model.
module tb_mult_cpa_pipe;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*W-1:0]  sum_vec = '0;
    logic [2*W-1:0]  carry_vec = '0;
    logic            op_hi = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    result;
`ifdef MULT_CPA_ZERO_FLAG_EN
    logic            zero_flag;
`endif

    mult_cpa_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .op_hi     (op_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef MULT_CPA_ZERO_FLAG_EN
        ,
        .zero_flag (zero_flag)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc = 0;
    logic [W-1:0] exp_q[$];
    int          t_q[$];
    bit          chk_lat = 0;
    bit          acc = 0;
    bit          prev_stall = 0;
    logic [W-1:0] prev_result = '0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: full 2W-bit product, carry bit i weighs 2^(i+1), top carry bit falls off.
    function automatic logic [W-1:0] ref_word(input logic [2*W-1:0] s, input logic [2*W-1:0] c,
                                              input logic hi);
        logic [2*W-1:0] p;
        p = s + (c << 1);
        return hi ? p[2*W-1:W] : p[W-1:0];
    endfunction

    // One clock: observe at negedge, update scoreboard, return at posedge+1.
    task automatic tick();
        logic exp_rdy;
        logic [W-1:0] e;
        int t;
        @(negedge clk);
        cyc++;
        acc = 0;
        exp_rdy = !flush && (exp_q.size() < 2 || out_ready);
        check("in_ready", in_ready, exp_rdy);
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, prev_result);
        end
        if (out_valid && exp_q.size() == 0) check("valid_without_entry", out_valid, 0);
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = t_q.pop_front();
            check("result", result, e);
`ifdef MULT_CPA_ZERO_FLAG_EN
            check("zero_flag", zero_flag, (e == '0));
`endif
            if (chk_lat) check("latency", cyc - t, 2);
            last_res = result;
        end
        if (flush) begin
            exp_q.delete();
            t_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(ref_word(sum_vec, carry_vec, op_hi));
            t_q.push_back(cyc);
            acc = 1;
            n_acc++;
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_result = result;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        case ($urandom_range(0, 7))
            0: begin sum_vec = '1; carry_vec = {$urandom, $urandom}; end
            1: begin sum_vec = {$urandom, $urandom}; carry_vec = '1; end
            2: begin sum_vec = '0; carry_vec = '0; end
            default: begin sum_vec = {$urandom, $urandom}; carry_vec = {$urandom, $urandom}; end
        endcase
        op_hi = $urandom_range(0, 1);
    endtask

    task automatic send(input logic [2*W-1:0] s, input logic [2*W-1:0] c, input logic hi);
        int k;
        sum_vec = s; carry_vec = c; op_hi = hi; in_valid = 1;
        k = 0;
        do begin tick(); k++; end while (!acc && k < 20);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int k;
        in_valid = 0; out_ready = 1; flush = 0;
        k = 0;
        while (exp_q.size() > 0 && k < 30) begin tick(); k++; end
        tick();
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        check("post_rst_in_ready", in_ready, 1);

        // Low-word and high-word with carry out of the low half
        chk_lat = 1;
        out_ready = 1;
        send(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        drain();
        check("lo_word_const", last_res, 32'h0000_0001);
        send(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1);
        drain();
        check("hi_word_c_lo", last_res, 32'h0000_0001);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1);
        drain();
        check("wrap_zero", last_res, 32'h0);

        // Eight back-to-back with continuous out_ready
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            tick();
            check("stream_accept", acc, 1);
        end
        drain();
        chk_lat = 0;

        // Backpressure: 3 offered over 5 stalled cycles, only 2 fit
        out_ready = 0;
        n_acc = 0;
        rand_data();
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acc) begin
                if (n_acc < 3) rand_data(); else in_valid = 0;
            end
        end
        check("stall_accepted", n_acc, 2);
        check("stall_in_ready", in_ready, 0);
        out_ready = 1;
        for (int i = 0; i < 10 && n_acc < 3; i++) tick();
        in_valid = 0;
        check("third_accepted", n_acc, 3);
        drain();

        // Flush with both stages full and a new input offered
        out_ready = 0;
        rand_data(); send(sum_vec, carry_vec, op_hi);
        rand_data(); send(sum_vec, carry_vec, op_hi);
        rand_data();
        in_valid = 1; flush = 1;
        tick();
        check("flush_no_accept", acc, 0);
        flush = 0; in_valid = 0;
        check("flush_out_valid", out_valid, 0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) tick();

        // Asynchronous reset mid-stream
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin rand_data(); tick(); end
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_result", result, 0);
        exp_q.delete(); t_q.delete(); prev_stall = 0;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin rand_data(); tick(); end
        drain();

        // Random traffic
        n_acc = 0;
        rand_data();
        for (int i = 0; i < 40000 && n_acc < 10000; i++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 199) == 0);
            tick();
            if (acc) rand_data();
        end
        flush = 0;
        check("random_count", n_acc >= 10000, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_cpa_pipe.md
Name: mult_cpa_pipe

Overview:
- Final carry-propagate stage of the 32-bit multiplier. Sits directly downstream of the 3:2 carry-save compression tree.
- Takes the redundant 64-bit sum/carry pair from the tree and resolves it to a binary product in two pipeline stages: low half first, then high half with a registered carry.
- Returns the 32-bit low or high word of the product to the ALU/writeback path over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width; the sum and carry vectors are 2*WIDTH bits and the result is WIDTH bits.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  sum_vec/carry_vec/op_hi are valid.
- in_ready  output  1  stage 1 can accept an entry this cycle.
- sum_vec  input  2*WIDTH  sum bits from the CSA tree; bit i has weight 2^i.
- carry_vec  input  2*WIDTH  carry bits from the CSA tree; bit i has weight 2^(i+1).
- op_hi  input  1  1: return product[2W-1:W]; 0: return product[W-1:0].
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  selected product word.

Behaviour:
- Arithmetic:
  - product = sum_vec + {carry_vec[2W-2:0],1'b0}, modulo 2^(2W).
  - carry_vec[2W-1] is discarded.
- Stage 1 (S1), on transfer in (in_valid & in_ready):
  - Register lo_sum = sum_vec[W-1:0] + {carry_vec[W-2:0],1'b0} (W bits).
  - Register c_lo = carry-out of that addition.
  - Register the upper operands: sum_vec[2W-1:W] and carry_vec[2W-2:W-1].
  - Register op_hi.
  - Set s1_valid.
- Stage 2 (S2), on S1 advance:
  - hi_sum = upper_sum + upper_carry + c_lo, truncated to W bits.
  - Register result = op_hi ? hi_sum : lo_sum.
  - Set out_valid.
- Stall rules (no bubble required when back-to-back):
  - S2 advances/accepts when (!out_valid | out_ready).
  - S1 passes to S2 when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | (!out_valid | out_ready).
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no stall.
  - Throughput of 1 per cycle under continuous out_ready.
- Backpressure:
  - While out_valid & !out_ready, result and out_valid hold stable.
  - S1 holds its contents. in_ready deasserts once S1 is occupied.
- Simultaneous events:
  - When S2 drains, S1 moves and a new input enters in the same cycle. No loss, no duplication.
- flush:
  - Clears s1_valid and out_valid at the next edge.
  - Ignores in_valid in that cycle (in_ready is forced to 0 while flush=1).
  - Flush has priority over all transfers.
- Reset (asynchronous, rst_n=0):
  - out_valid=0, result=0, s1_valid=0, all data registers 0.
  - in_ready reads 1 during and after reset.
  - Reset mid-operation discards all in-flight entries. No output appears for them.
- Data registers update only on transfer, which gives a low-power hold.
- out_valid never asserts without a prior accepted input.

Optional Feature:
- Macro MULT_CPA_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero_flag (1 bit).
  - zero_flag is registered in S2 alongside result and equals (selected word == 0).
  - Reset value 0. Held under backpressure. Cleared by flush.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then sum_vec=64'h0000_0000_FFFF_FFFF, carry_vec=64'h0000_0000_0000_0001, op_hi=0 -> after 2 cycles result=32'h0000_0001 (product 64'h1_0000_0001). Same inputs with op_hi=1 -> result=32'h0000_0001, which checks c_lo propagation.
- sum_vec=64'hFFFF_FFFF_FFFF_FFFF, carry_vec=64'h8000_0000_0000_0001, op_hi=1 -> product wraps to 64'h1 and result=0. Carry bit 63 is dropped. zero_flag=1 when MULT_CPA_ZERO_FLAG_EN.
- Stream 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles, in order, first 2 cycles after first input.
- Hold out_ready=0 for 5 cycles with 3 inputs offered -> only 2 accepted, in_ready=0, result stable; then release -> remaining results in order, no duplicates.
- Assert flush with both stages full and in_valid=1 -> next cycle out_valid=0, s1 empty, flushed input not accepted.
- Assert rst_n=0 asynchronously mid-stream -> out_valid drops immediately, result=0; resume -> first output only from new inputs.
- Randomised: 10k random sum/carry pairs -> result matches the reference sum, low/high word selected by op_hi.
